// File: rtl/id_ex_skid_pkg.sv
// Shared definitions for the ID/EX skid stage: the bubble instruction and
// the width of the packed payload that travels through the buffer.
package id_ex_skid_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), shown on the outputs for a bubble.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam int          INST_W   = 32;

    // Width of {inst, inst_addr, op1, op2, rd_addr, reg_wen}.
    function automatic int payload_width(input int xlen, input int reg_aw);
        return INST_W + 3 * xlen + reg_aw + 1;
    endfunction

endpackage

// File: rtl/id_ex_skid_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush. The input
// ready is registered, so no combinational path runs from out_ready_i to in_ready_o.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic [1:0]   occupancy_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           in_ready_q;
    logic           accept;
    logic           drain;

    assign accept = in_valid_i & in_ready_q;
    assign drain  = (state_q != EMPTY) & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data_i;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_data_i;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can move the state.
                if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A concurrent drain still completes: execute already owns that entry.
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline stage: packs the decode fields into one payload, buffers it in
// a two-entry skid buffer and presents a NOP bubble whenever the head is empty.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_wen_i,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_wen_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        occupancy_o
);

    localparam int PW = payload_width(XLEN, REG_AW);

    logic [PW-1:0]     in_pld;
    logic [PW-1:0]     head_pld;
    logic              head_valid;
    logic [31:0]       head_inst;
    logic [XLEN-1:0]   head_addr;
    logic [XLEN-1:0]   head_op1;
    logic [XLEN-1:0]   head_op2;
    logic [REG_AW-1:0] head_rd;
    logic              head_wen;

    assign in_pld = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};

    skid_buf #(
        .W (PW)
    ) u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_pld),
        .in_ready_o  (in_ready_o),
        .out_valid_o (head_valid),
        .out_data_o  (head_pld),
        .out_ready_i (out_ready_i),
        .occupancy_o (occupancy_o)
    );

    assign {head_inst, head_addr, head_op1, head_op2, head_rd, head_wen} = head_pld;

    // Bubble muxing keeps stale data in the buffer from ever reaching execute.
    assign out_valid_o = head_valid;
    assign inst_o      = head_valid ? head_inst : INST_NOP;
    assign inst_addr_o = head_valid ? head_addr : '0;
    assign op1_o       = head_valid ? head_op1  : '0;
    assign op2_o       = head_valid ? head_op2  : '0;
    assign rd_addr_o   = head_valid ? head_rd   : '0;
    assign reg_wen_o   = head_valid & head_wen;

endmodule
